// File: rtl/seg7_pkg.sv
// Shared definitions for the seg7_count_display block.
// Contents: converter FSM state encoding, the committed display record type,
// segment constants (active-low gfedcba), the anode-off pattern, and the
// BCD-to-segment lookup function.
package seg7_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CONV   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Display contents, always written as a whole so the scanner never sees
  // a half-updated result.
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
    logic       oor;
  } disp_t;

  function automatic logic [6:0] digit_code(input logic [3:0] bcd);
    logic [6:0] code;
    case (bcd)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg7_count_display_if.sv
// Bus between the count source and the display driver.
//   value : binary count from the upstream counter
//   an    : digit anodes, active-low
//   seg   : {dp,g,f,e,d,c,b,a}, active-low
//   busy  : conversion in progress
// master = count source / observer, slave = seg7_count_display.
interface seg7_count_display_if #(
  parameter int VALUE_BITS = 8
);
  logic [VALUE_BITS-1:0] value;
  logic [3:0]            an;
  logic [7:0]            seg;
  logic                  busy;

  modport master (output value, input an, seg, busy);
  modport slave  (input value, output an, seg, busy);
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to 7-segment decoder.
//   bcd   : 4-bit digit, non-decimal codes decode to blank
//   blank : forces all segments off
//   seg   : gfedcba, active-low
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : digit_code(bcd);
  end

endmodule

// File: rtl/seg7_count_display.sv
// Converts an 8-bit binary count (0..99) to two BCD digits with a
// repeated-subtract-10 engine and drives a 4-digit common-anode display by
// time-multiplexed scanning. Values above 99 show "--".
//   clk : system clock
//   rst : asynchronous reset, active-low
//   bus : slave modport (value in; an, seg, busy out, all registered)
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | capture value into work, clear accumulators
// ST_CONV   | subtract 10 per cycle until work < 10, or flag >99
// ST_COMMIT | copy accumulators to display registers in one cycle
module seg7_count_display
  import seg7_pkg::*;
#(
  parameter int VALUE_BITS    = 8,
  parameter int SCAN_DIV_BITS = 17,
  parameter int BLANK_LEADING = 1
) (
  input  logic                clk,
  input  logic                rst,
  seg7_count_display_if.slave bus
);

  logic [1:0]               state;
  logic [VALUE_BITS-1:0]    work;
  logic [3:0]               tens_acc;
  logic [3:0]               ones_acc;
  logic                     oor_acc;
  disp_t                    disp;
  logic                     busy_q;

  logic [SCAN_DIV_BITS-1:0] cnt;
  logic [1:0]               sel;
  logic [3:0]               an_nxt;
  logic [3:0]               dig_bcd;
  logic                     dig_blank;
  logic [6:0]               dec_seg;
  logic [7:0]               seg_nxt;
  logic [3:0]               an_q;
  logic [7:0]               seg_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      work     <= '0;
      tens_acc <= '0;
      ones_acc <= '0;
      oor_acc  <= 1'b0;
      disp     <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          work     <= bus.value;
          tens_acc <= '0;
          oor_acc  <= 1'b0;
          busy_q   <= 1'b1;
          state    <= ST_CONV;
        end
        ST_CONV: begin
          // Only the freshly captured value can exceed 99; once the loop
          // starts subtracting, work is already below 100.
          if (work > VALUE_BITS'(99)) begin
            oor_acc  <= 1'b1;
            ones_acc <= '0;
            state    <= ST_COMMIT;
          end else if (work >= VALUE_BITS'(10)) begin
            work     <= work - VALUE_BITS'(10);
            tens_acc <= tens_acc + 4'd1;
          end else begin
            ones_acc <= work[3:0];
            state    <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          disp   <= '{tens: tens_acc, ones: ones_acc, oor: oor_acc};
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign sel = cnt[SCAN_DIV_BITS-1 -: 2];

  always_comb begin
    an_nxt    = AN_OFF;
    dig_bcd   = disp.ones;
    dig_blank = 1'b1;
    case (sel)
      2'd0: begin
        an_nxt    = 4'b1110;
        dig_bcd   = disp.ones;
        dig_blank = 1'b0;
      end
      2'd1: begin
        an_nxt    = 4'b1101;
        dig_bcd   = disp.tens;
        dig_blank = (BLANK_LEADING != 0) && (disp.tens == 4'd0) && !disp.oor;
      end
      2'd2:    an_nxt = 4'b1011;
      default: an_nxt = 4'b0111;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd   (dig_bcd),
    .blank (dig_blank),
    .seg   (dec_seg)
  );

  // Slots 2/3 are always blank; the dash override only applies to slots 0/1.
  assign seg_nxt = {1'b1, (disp.oor && !sel[1]) ? SEG_DASH : dec_seg};

  // an and seg share one register stage so a slot change never shows the
  // previous digit's segments on the new anode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      an_q  <= AN_OFF;
      seg_q <= 8'hFF;
    end else begin
      cnt   <= cnt + 1'b1;
      an_q  <= an_nxt;
      seg_q <= seg_nxt;
    end
  end

  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_seg7_count_display.sv
// Directed bench for seg7_count_display: instance a has leading-zero
// blanking, instance b does not; both see the same value and scan timing.
module tb_seg7_count_display;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  seg7_count_display_if #(.VALUE_BITS(8)) ifa ();
  seg7_count_display_if #(.VALUE_BITS(8)) ifb ();

  seg7_count_display #(.VALUE_BITS(8), .SCAN_DIV_BITS(4), .BLANK_LEADING(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  seg7_count_display #(.VALUE_BITS(8), .SCAN_DIV_BITS(4), .BLANK_LEADING(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_value(input logic [7:0] v);
    ifa.value = v;
    ifb.value = v;
  endtask

  task automatic wait_busy(input logic level, input string tag);
    for (int i = 0; i < 40; i++) begin
      if (ifa.busy === level) break;
      tick();
    end
    chk(tag, 32'(ifa.busy), 32'(level));
  endtask

  // Guarantees at least one complete conversion of the current value.
  task automatic settle(input string tag);
    wait_busy(1'b0, tag);
    wait_busy(1'b1, tag);
    wait_busy(1'b0, tag);
  endtask

  task automatic check_slot(input int which, input logic [3:0] an_exp,
                            input logic [7:0] seg_exp, input string tag);
    tick();
    for (int i = 0; i < 20; i++) begin
      if (((which != 0) ? ifb.an : ifa.an) === an_exp) break;
      tick();
    end
    chk({tag, "_an"}, 32'((which != 0) ? ifb.an : ifa.an), 32'(an_exp));
    chk({tag, "_seg"}, 32'((which != 0) ? ifb.seg : ifa.seg), 32'(seg_exp));
  endtask

  task automatic mon38(input string tag);
    if (ifa.an === 4'b1110) chk({tag, "_ones"}, 32'(ifa.seg), 32'h80);
    if (ifa.an === 4'b1101) chk({tag, "_tens"}, 32'(ifa.seg), 32'hB0);
  endtask

  initial begin
    logic [7:0] ones_order [4];
    int pos;
    int n;
    int j;
    logic [7:0] wrap_vals [3];

    ones_order[0] = 8'h80;
    ones_order[1] = 8'h90;
    ones_order[2] = 8'hC0;
    ones_order[3] = 8'hF9;
    wrap_vals[0] = 8'd99;
    wrap_vals[1] = 8'd0;
    wrap_vals[2] = 8'd1;

    // Reset held with a live value on the input.
    set_value(8'd42);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_an", 32'(ifa.an), 32'hF);
      chk("rst_seg", 32'(ifa.seg), 32'hFF);
      chk("rst_busy", 32'(ifa.busy), 32'h0);
      chk("rst_an_b", 32'(ifb.an), 32'hF);
    end
    rst = 1'b1;
    tick();
    chk("rel_busy", 32'(ifa.busy), 32'h1);

    // 99: worst-case conversion, busy for 10 CONV + 1 COMMIT cycles.
    set_value(8'd99);
    wait_busy(1'b0, "w99_lo");
    wait_busy(1'b1, "w99_hi");
    n = 0;
    while (ifa.busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("busy99_len", 32'(n), 32'd11);
    check_slot(0, 4'b1110, 8'h90, "v99_s0");
    check_slot(0, 4'b1101, 8'h90, "v99_s1");

    // 7: leading blank on a, leading zero on b.
    set_value(8'd7);
    settle("w7");
    check_slot(0, 4'b1101, 8'hFF, "v7_s1");
    check_slot(0, 4'b1110, 8'hF8, "v7_s0");
    check_slot(1, 4'b1101, 8'hC0, "v7b_s1");
    check_slot(1, 4'b1110, 8'hF8, "v7b_s0");

    // 150: out of range, single CONV cycle, dashes on slots 0/1.
    set_value(8'd150);
    settle("w150");
    wait_busy(1'b1, "w150_hi");
    n = 0;
    while (ifa.busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("busy150_len", 32'(n), 32'd2);
    check_slot(0, 4'b1110, 8'hBF, "v150_s0");
    check_slot(0, 4'b1101, 8'hBF, "v150_s1");
    check_slot(0, 4'b1011, 8'hFF, "v150_s2");
    check_slot(0, 4'b0111, 8'hFF, "v150_s3");
    check_slot(1, 4'b1101, 8'hBF, "v150b_s1");

    // 38 -> 61 changed mid-conversion: 38 stays until 61 commits.
    set_value(8'd38);
    settle("w38");
    check_slot(0, 4'b1110, 8'h80, "v38_s0");
    check_slot(0, 4'b1101, 8'hB0, "v38_s1");
    wait_busy(1'b1, "w38_hi");
    tick();
    set_value(8'd61);
    for (int i = 0; i < 40 && ifa.busy === 1'b1; i++) begin
      mon38("mid38");
      tick();
    end
    wait_busy(1'b1, "w61_hi");
    for (int i = 0; i < 40 && ifa.busy === 1'b1; i++) begin
      mon38("mid61");
      tick();
    end
    check_slot(0, 4'b1110, 8'hF9, "v61_s0");
    check_slot(0, 4'b1101, 8'h82, "v61_s1");

    // Upstream counter wrap 98,99,0,1: ones digit only moves forward
    // through that order and no dash ever appears.
    set_value(8'd98);
    settle("w98");
    check_slot(0, 4'b1110, 8'h80, "v98_s0");
    pos = 0;
    for (int k = 0; k < 3; k++) begin
      set_value(wrap_vals[k]);
      for (int c = 0; c < 16; c++) begin
        tick();
        if (ifa.an === 4'b1110) begin
          j = -1;
          for (int q = 0; q < 4; q++) if (ifa.seg === ones_order[q]) j = q;
          chk("wrap_ones_order", 32'(j >= pos), 32'd1);
          if (j > pos) pos = j;
        end
        if (ifa.an === 4'b1101)
          chk("wrap_tens", 32'(ifa.seg === 8'h90 || ifa.seg === 8'hFF), 32'd1);
      end
    end
    for (int c = 0; c < 40 && pos != 3; c++) begin
      tick();
      if (ifa.an === 4'b1110 && ifa.seg === 8'hF9) pos = 3;
    end
    chk("wrap_reached_1", 32'(pos), 32'd3);
    check_slot(0, 4'b1101, 8'hFF, "v1_s1");
    check_slot(1, 4'b1101, 8'hC0, "v1b_s1");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
